// File: rtl/dmem_wait_responder_if.sv
// Data-memory request/response bus between a CPU (master) and a memory responder (slave).
// Two independent valid/ready handshakes: one for requests, one for responses.
interface dmem_wait_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a
// byte-lane-masked access to an internal word array and a held response.
module dmem_wait_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  reset,
  dmem_wait_responder_if.slave bus
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WaitInit  = 4'(WAIT_CYCLES);
  localparam bit          NoWait    = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        rsp_valid_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic            accept;
  logic            acc_fire;
  logic            acc_we;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;
  logic [32:0]     offset;
  logic            in_range;
  logic            be_ok;
  logic            acc_legal;
  logic [IdxW-1:0] idx;

  assign bus.req_ready = (state_q == StIdle) & ~reset;
  assign accept        = bus.req_ready & bus.req_valid;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // With no wait states the access uses the live request on the accepting edge.
  always_comb begin
    acc_fire  = (state_q == StWait) && (cnt_q == 4'd1);
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (NoWait) begin
      acc_fire  = accept;
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_be    = bus.req_be;
    end
  end

  always_comb begin
    offset   = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    in_range = ~offset[32] & (offset < SpanBytes);
    case (acc_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
    acc_legal = in_range & be_ok;
    idx       = offset[IdxW+1:2];
  end

  always_ff @(posedge clk) begin
    if (acc_fire && acc_legal && acc_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (acc_fire) begin
        rdata_q     <= (acc_legal && !acc_we) ? mem[idx] : 32'd0;
        err_q       <= ~acc_legal;
        rsp_valid_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            cnt_q   <= WaitInit;
            state_q <= NoWait ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
